// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial LSB-first subtractor D = A - B with start/busy/done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             bout_q, bout_d;

    logic w_a, w_b, w_diff, w_bw_next;

    // Single half-subtractor-plus-borrow cell shared across all bit positions
    always_comb begin
        w_a       = a_sh_q[0];
        w_b       = b_sh_q[0];
        w_diff    = w_a ^ w_b ^ bw_q;
        w_bw_next = (~w_a & w_b) | (~(w_a ^ w_b) & bw_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {w_diff, res_q[WIDTH-1:1]};
                bw_d   = w_bw_next;
                if (cnt_q == C_LAST) begin
                    cnt_d   = '0;
                    bout_d  = w_bw_next;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign D    = res_q;
    assign Bout = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Directed and random self-checking bench for serial_subtractor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int LIMIT = 30;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       Bout;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 8'h5A;
        B     = 8'hC3;
    endtask

    // Counts rising edges until done is seen; LIMIT+1 means it never came.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < LIMIT);
        if (!done) n = LIMIT + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, D, Bout} !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold: busy=%b done=%b D=%h Bout=%b, required all 0", busy, done, D, Bout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, D, Bout} !== 11'd0) begin
                bad++;
                $display("FAIL reset_idle%0d: busy=%b done=%b D=%h Bout=%b, required all 0", i, busy, done, D, Bout);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        start_op(8'd5, 8'd3);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        wait_done(n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL basic_latency: edges=%0d, required 8", n);
        end
        total++;
        if (D !== 8'h02 || Bout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: D=%h Bout=%b busy=%b, required D=02 Bout=0 busy=0", D, Bout, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || D !== 8'h02 || Bout !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse: done=%b D=%h Bout=%b, required done=0 D=02 Bout=0", done, D, Bout);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [5] = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h80};
        logic [7:0] vb [5] = '{8'h05, 8'h00, 8'hFF, 8'h01, 8'h7F};
        logic [7:0] vd [5] = '{8'hFE, 8'h00, 8'h00, 8'hFF, 8'h01};
        logic       vo [5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_done(n);
            total++;
            if (n !== 8 || D !== vd[i] || Bout !== vo[i]) begin
                bad++;
                $display("FAIL boundary %h-%h: edges=%0d D=%h Bout=%b, required edges=8 D=%h Bout=%b",
                         va[i], vb[i], n, D, Bout, vd[i], vo[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        start_op(8'd9, 8'd4);
        repeat (2) @(negedge clk);
        A     = 8'd1;
        B     = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        total++;
        if (n !== 5 || D !== 8'h05 || Bout !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start: edges=%0d D=%h Bout=%b, required edges=5 D=05 Bout=0", n, D, Bout);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(8'd20, 8'd7);
        wait_done(n);
        total++;
        if (n !== 8 || D !== 8'h0D || Bout !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: edges=%0d D=%h Bout=%b, required edges=8 D=0d Bout=0", n, D, Bout);
        end
        A     = 8'd7;
        B     = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(n);
        total++;
        if (n + 1 !== 9 || D !== 8'hF3 || Bout !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: done_gap=%0d D=%h Bout=%b, required gap=9 D=f3 Bout=1", n + 1, D, Bout);
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        int n;
        pulses = 0;
        start_op(8'd200, 8'd100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        if (done) pulses++;
        total++;
        if ({busy, done, D, Bout} !== 11'd0) begin
            bad++;
            $display("FAIL midrst_clear: busy=%b done=%b D=%h Bout=%b, required all 0", busy, done, D, Bout);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses !== 0 || {busy, D, Bout} !== 10'd0) begin
            bad++;
            $display("FAIL midrst_nodone: pulses=%0d busy=%b D=%h Bout=%b, required 0 pulses, outputs 0", pulses, busy, D, Bout);
        end
        // Start held across reset release: reset wins, then first high edge accepts
        A     = 8'd50;
        B     = 8'd60;
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_wins: busy=%b, required 0", busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_first_start: busy=%b, required 1", busy);
        end
        wait_done(n);
        total++;
        if (n !== 8 || D !== 8'hF6 || Bout !== 1'b1) begin
            bad++;
            $display("FAIL rst_first_result: edges=%0d D=%h Bout=%b, required edges=8 D=f6 Bout=1", n, D, Bout);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, exp_d;
        logic       exp_o;
        int n;
        for (int i = 0; i < 200; i++) begin
            a     = 8'($urandom_range(0, 255));
            b     = 8'($urandom_range(0, 255));
            exp_d = a - b;
            exp_o = (a < b);
            start_op(a, b);
            wait_done(n);
            total++;
            if (n !== 8 || D !== exp_d || Bout !== exp_o) begin
                bad++;
                $display("FAIL random %h-%h: edges=%0d D=%h Bout=%b, required edges=8 D=%h Bout=%b",
                         a, b, n, D, Bout, exp_d, exp_o);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first subtractor that computes D = A − B over WIDTH clock cycles. It uses a single half-subtractor-plus-borrow cell and a borrow flip-flop. It is the inverse-direction companion of the combinational half-adder datapath, for area-constrained arithmetic where a WIDTH-bit parallel subtractor is not justified. A start/busy/done handshake controls it, and the result stays held until the next operation is started.

## Interface

- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  request; sampled on each rising edge; accepted only in IDLE or DONE
- A  input  WIDTH  minuend; sampled on the accepting edge only
- B  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; result valid
- D  output  WIDTH  difference A − B mod 2^WIDTH
- Bout  output  1  final borrow; 1 iff A < B (unsigned)

## Operation

- State machine states:
  - IDLE: waits for start. start=1 latches A and B into shift registers, clears the borrow flop and bit counter, then moves to RUN.
  - RUN: processes one bit per edge, LSB first. After the WIDTH-th bit it moves to DONE.
  - DONE: done=1 for exactly one cycle. start=1 in this cycle is accepted like in IDLE and moves to RUN; otherwise the next state is IDLE.
- Per-bit cell in RUN, with a = A_sh[0], b = B_sh[0], bw = borrow flop:
  - d = a ^ b ^ bw
  - bw_next = (~a & b) | (~(a ^ b) & bw)
- Shifting in RUN:
  - A_sh and B_sh shift right by one.
  - d enters the result register at the MSB and shifts right, so after WIDTH bits bit i of D is the i-th processed bit.
- Completion: on the edge that processes the last bit, Bout is loaded with bw_next and the counter returns to 0.
- Counter: log2-sized, counts 0..WIDTH−1 in RUN and wraps to 0 on the last bit. It is not observable externally.
- start while busy=1 is ignored. There is no queueing and no error flag.
- A and B changes outside the accepting edge have no effect.
- D and Bout are valid from the done cycle onward. They are held through IDLE until the next accepted start.
- During RUN, D shows the shifting partial result and is not valid. Bout holds its previous value until completion.
- Arithmetic:
  - Unsigned modular subtraction.
  - Two's-complement results can be read from D directly.
  - Bout is the inverted carry-out of A + ~B + 1.

## Timing

- Reset: every rising edge with rst_n=0 forces state=IDLE, busy=0, done=0, D=0, Bout=0, borrow flop 0, counter 0, shift registers 0.
- Reset mid-RUN or mid-DONE aborts the operation with no done pulse. The first start is accepted on the first edge with rst_n=1.
- Edge numbering, with start accepted at edge 0:
  - busy=1 from edge 0 to edge WIDTH.
  - bits are processed at edges 1..WIDTH.
  - done=1 and busy=0 in the cycle after edge WIDTH.
- Latency: start-accept edge to done assertion is WIDTH cycles.
- Throughput: back-to-back operation, with start held during DONE, gives one result every WIDTH+1 cycles.
- start=1 and rst_n=0 on the same edge: reset wins.

## Test plan

- Reset check: hold rst_n=0 for 3 edges, then release → busy=0, done=0, D=0, Bout=0, and all stay 0 with start=0.
- Basic difference: WIDTH=8, A=5, B=3, start for one cycle → done exactly 8 cycles after the accepting edge, D=8'h02, Bout=0, done high for exactly 1 cycle.
- Negative result: A=3, B=5 → D=8'hFE, Bout=1.
- Boundary operands:
  - A=0, B=0 → D=0, Bout=0
  - A=8'hFF, B=8'hFF → D=0, Bout=0
  - A=0, B=1 → D=8'hFF, Bout=1
  - A=8'h80, B=8'h7F → D=1, Bout=0
- Handshake rules:
  - Start 9−4, then pulse start with A=1, B=2 at RUN cycle 3 → ignored, D=5, Bout=0.
  - Holding start=1 with new operands in the DONE cycle starts the next operation immediately, with its done 9 cycles after the previous done.
- Mid-operation reset: assert rst_n=0 at RUN cycle 4 of A=200, B=100 → no done pulse, and outputs are 0 after reset.
- Randomized sweep: 200 random A/B pairs → D == (A−B) mod 256 and Bout == (A<B).
